// File: rtl/serial_alu_ctrl.sv
// Multi-cycle 16-bit ALU controller. Add, subtract and packed nibble add run one
// nibble per cycle on a shared 4-bit slice; shifts run one bit per cycle.
module serial_alu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        ready,
  output logic        done,
  output logic [15:0] result,
  output logic        ovfl,
  output logic        zero,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StNib, StShift, StDone} state_e;

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpSub  = 3'b001;
  localparam logic [2:0] OpPadd = 3'b010;
  localparam logic [2:0] OpSll  = 3'b011;
  localparam logic [2:0] OpSra  = 3'b100;

  state_e      state_q;
  logic [2:0]  op_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [15:0] work_q;
  logic [1:0]  idx_q;
  logic [3:0]  cnt_q;
  logic        carry_q;
  logic        povf_q;

  logic [3:0]  a_nib;
  logic [3:0]  b_raw;
  logic [3:0]  b_nib;
  logic        cin;
  logic [4:0]  sum;
  logic        nib_ovf;
  logic [15:0] nib_result;
  logic        illegal_q;

  assign illegal_q = (op_q > OpSra);

  // Shared nibble slice; the index selects which 4 bits of A/B/result it works on.
  always_comb begin
    a_nib = a_q[{idx_q, 2'b00} +: 4];
    b_raw = b_q[{idx_q, 2'b00} +: 4];
    b_nib = (op_q == OpSub) ? ~b_raw : b_raw;
    if (op_q == OpPadd) begin
      cin = 1'b0;
    end else if (idx_q == 2'd0) begin
      cin = (op_q == OpSub);
    end else begin
      cin = carry_q;
    end
    sum     = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, cin};
    nib_ovf = (a_nib[3] == b_nib[3]) && (sum[3] != a_nib[3]);
    nib_result = result;
    nib_result[{idx_q, 2'b00} +: 4] = sum[3:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpAdd;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      povf_q  <= 1'b0;
      ready   <= 1'b1;
      done    <= 1'b0;
      result  <= '0;
      ovfl    <= 1'b0;
      zero    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            work_q  <= a;
            idx_q   <= '0;
            cnt_q   <= (op == OpSll || op == OpSra) ? b[3:0] : 4'd0;
            carry_q <= 1'b0;
            povf_q  <= 1'b0;
            ready   <= 1'b0;
            // Illegal ops pass through SHIFT with a zero count to finish one edge later.
            state_q <= (op <= OpPadd) ? StNib : StShift;
          end
        end
        StNib: begin
          result  <= nib_result;
          carry_q <= sum[4];
          povf_q  <= povf_q | nib_ovf;
          idx_q   <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_q <= StDone;
            done    <= 1'b1;
            zero    <= (nib_result == 16'h0000);
            err     <= 1'b0;
            ovfl    <= (op_q == OpPadd) ? (povf_q | nib_ovf) : nib_ovf;
          end
        end
        StShift: begin
          if (illegal_q) begin
            state_q <= StDone;
            done    <= 1'b1;
            result  <= '0;
            zero    <= 1'b1;
            err     <= 1'b1;
            ovfl    <= 1'b0;
          end else if (cnt_q == 4'd0) begin
            state_q <= StDone;
            done    <= 1'b1;
            result  <= work_q;
            zero    <= (work_q == 16'h0000);
            err     <= 1'b0;
            ovfl    <= 1'b0;
          end else begin
            cnt_q  <= cnt_q - 4'd1;
            work_q <= (op_q == OpSra) ? {work_q[15], work_q[15:1]} : {work_q[14:0], 1'b0};
          end
        end
        StDone: begin
          state_q <= StIdle;
          ready   <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Bench for serial_alu_ctrl: directed corner cases plus random ops checked against
// an arithmetic reference model, including latency and reset behaviour.
module tb_serial_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        ready;
  logic        done;
  logic [15:0] result;
  logic        ovfl;
  logic        zero;
  logic        err;

  int tests = 0;
  int fails = 0;

  serial_alu_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .done   (done),
    .result (result),
    .ovfl   (ovfl),
    .zero   (zero),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int sext4(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  function automatic int sext16(input logic [15:0] v);
    int t;
    t = int'(v);
    return (t >= 32768) ? t - 65536 : t;
  endfunction

  // Reference model: result, overflow, error and done latency in edges after acceptance.
  task automatic model(input logic [2:0] o, input logic [15:0] aa, input logic [15:0] bb,
                       output logic [15:0] res, output logic ov, output logic er,
                       output int lat);
    int s;
    int an;
    int bn;
    logic signed [15:0] sa;
    res = 16'h0000;
    ov  = 1'b0;
    er  = 1'b0;
    case (o)
      3'd0: begin
        s   = sext16(aa) + sext16(bb);
        res = aa + bb;
        ov  = (s > 32767) || (s < -32768);
        lat = 4;
      end
      3'd1: begin
        s   = sext16(aa) - sext16(bb);
        res = aa - bb;
        ov  = (s > 32767) || (s < -32768);
        lat = 4;
      end
      3'd2: begin
        for (int i = 0; i < 4; i++) begin
          an  = int'((aa >> (4 * i)) & 16'hF);
          bn  = int'((bb >> (4 * i)) & 16'hF);
          s   = sext4(an) + sext4(bn);
          if (s > 7 || s < -8) ov = 1'b1;
          res = res | 16'(((an + bn) % 16) << (4 * i));
        end
        lat = 4;
      end
      3'd3: begin
        res = aa << bb[3:0];
        lat = int'(bb[3:0]) + 1;
      end
      3'd4: begin
        sa  = aa;
        res = sa >>> bb[3:0];
        lat = int'(bb[3:0]) + 1;
      end
      default: begin
        er  = 1'b1;
        lat = 1;
      end
    endcase
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [15:0] aa,
                        input logic [15:0] bb, input bit hold_start);
    logic [15:0] er_res;
    logic        er_ov;
    logic        er_err;
    int          er_lat;
    int          lat;
    model(o, aa, bb, er_res, er_ov, er_err, er_lat);
    @(negedge clk);
    check({name, ".ready_before"}, 32'(ready), 32'd1);
    start = 1'b1;
    op    = o;
    a     = aa;
    b     = bb;
    @(posedge clk);
    #1;
    if (!hold_start) start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (!done) check({name, ".ready_busy"}, 32'(ready), 32'd0);
    end
    start = 1'b0;
    check({name, ".latency"}, 32'(lat), 32'(er_lat));
    check({name, ".result"}, 32'(result), 32'(er_res));
    check({name, ".ovfl"}, 32'(ovfl), 32'(er_ov));
    check({name, ".zero"}, 32'(zero), 32'(er_res == 16'h0000));
    check({name, ".err"}, 32'(err), 32'(er_err));
    check({name, ".ready_at_done"}, 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    check({name, ".done_single"}, 32'(done), 32'd0);
    check({name, ".ready_after"}, 32'(ready), 32'd1);
    check({name, ".result_held"}, 32'(result), 32'(er_res));
  endtask

  initial begin
    #12;
    check("reset.ready", 32'(ready), 32'd1);
    check("reset.done", 32'(done), 32'd0);
    check("reset.result", 32'(result), 32'd0);
    check("reset.flags", {29'd0, ovfl, zero, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add_ovf", 3'd0, 16'h7FFF, 16'h0001, 1'b0);
    run_op("sub_neg", 3'd1, 16'h0005, 16'h0007, 1'b0);
    run_op("sub_zero", 3'd1, 16'h1234, 16'h1234, 1'b0);
    run_op("padd_ovf", 3'd2, 16'h7123, 16'h1111, 1'b0);
    run_op("padd_ok", 3'd2, 16'h1234, 16'h1111, 1'b0);
    run_op("sra4", 3'd4, 16'h8000, 16'h0004, 1'b0);
    run_op("sll15", 3'd3, 16'h00F1, 16'h000F, 1'b0);
    run_op("sll0", 3'd3, 16'hBEEF, 16'h0000, 1'b0);
    run_op("illegal", 3'd7, 16'h1234, 16'h5678, 1'b0);
    run_op("sra_hold", 3'd4, 16'hA5A5, 16'h0006, 1'b1);
    run_op("sub_min", 3'd1, 16'h8000, 16'h0001, 1'b0);

    // Abort an add at nibble index 2.
    @(negedge clk);
    start = 1'b1;
    op    = 3'd0;
    a     = 16'h1234;
    b     = 16'h1111;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("abort.partial_nonzero", 32'(result != 16'h0000), 32'd1);
    rst = 1'b1;
    #1;
    check("abort.ready", 32'(ready), 32'd1);
    check("abort.result", 32'(result), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("abort.no_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op("after_reset", 3'd0, 16'h0102, 16'h0304, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op("random", 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_alu_ctrl.md
SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 16 bits, processed as four 4-bit nibble slices.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled only while ready=1.
REQ-005 op  input  3  operation: 000 ADD, 001 SUB, 010 PADDSB, 011 SLL, 100 SRA, 101-111 illegal.
REQ-006 a  input  16  operand A; the shift source for SLL/SRA.
REQ-007 b  input  16  operand B; b[3:0] is the shift amount for SLL/SRA.
REQ-008 ready  output  1  high exactly when the FSM is in IDLE.
REQ-009 done  output  1  one-cycle pulse; result and flags are valid in this cycle.
REQ-010 result  output  16  registered result; held stable from done until the next accepted start.
REQ-011 ovfl  output  1  signed overflow (ADD/SUB) or any-nibble error (PADDSB), registered; 0 for other ops.
REQ-012 zero  output  1  registered, result==16'h0000, updated with result.
REQ-013 err  output  1  registered illegal-op flag, updated with result.

Function
REQ-014 States SHALL be IDLE, NIB, SHIFT and DONE; DONE SHALL always go to IDLE on the next edge.
REQ-015 At the edge k where start=1 in IDLE, the block SHALL latch a, b and op, and clear the internal nibble index and shift counter.
REQ-016 The block SHALL ignore start in every state other than IDLE, with no effect on the in-flight operation.
REQ-017 For ADD/SUB/PADDSB, the edge k transition SHALL be IDLE->NIB with idx=0.
REQ-018 At edges k+1..k+4, the NIB state SHALL compute nibble idx with one shared 4-bit add/sub slice, write it into result bits [4*idx+3:4*idx], and increment idx.
REQ-019 At edge k+4, after idx=3, the FSM SHALL go NIB->DONE; done SHALL therefore be high in the cycle after edge k+4.
REQ-020 SUB SHALL invert the B nibble and inject carry 1 at nibble 0.
REQ-021 For ADD/SUB, the carry SHALL be registered between nibbles, and ovfl SHALL be the signed overflow of nibble 3 only.
REQ-022 For PADDSB, carry-in SHALL be 0 for every nibble with no carry between nibbles, each nibble SHALL wrap modulo 16, and ovfl SHALL be the OR of the four per-nibble signed overflows.
REQ-023 For SLL/SRA, the edge k transition SHALL be IDLE->SHIFT with cnt=b[3:0] and a working register equal to A.
REQ-024 Each SHIFT edge with cnt!=0 SHALL shift by one bit and decrement cnt; SLL SHALL fill with 0 and SRA SHALL replicate bit 15.
REQ-025 A SHIFT edge with cnt==0 SHALL go to DONE; an amount n therefore gives done in the cycle after edge k+n+1, so amount 0 gives done after edge k+1.
REQ-026 An illegal op SHALL go IDLE->DONE at edge k+1 with result=0, err=1, ovfl=0 and zero=1.
REQ-027 The zero flag SHALL be computed from the final 16-bit result at DONE entry.
REQ-028 ready and done SHALL never be high in the same cycle.

Reset
REQ-029 While rst=1, asynchronously: state=IDLE, result=0, ovfl=0, zero=0, err=0, done=0, ready=1, and idx, cnt and carry cleared.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-031 The first start after reset release SHALL be accepted on the next edge.

Verification
REQ-032 ADD a=16'h7FFF, b=16'h0001 -> result 16'h8000, ovfl=1, zero=0, done after edge k+4, single cycle.
REQ-033 SUB a=16'h0005, b=16'h0007 -> result 16'hFFFE, ovfl=0; SUB a=b=16'h1234 -> result 0, zero=1.
REQ-034 PADDSB a=16'h7123, b=16'h1111 -> result 16'h8234, ovfl=1; a=16'h1234, b=16'h1111 -> 16'h2345, ovfl=0.
REQ-035 SRA a=16'h8000, b[3:0]=4 -> 16'hF800 with done after edge k+5; SLL a=16'h00F1, amount 15 -> 16'h8000 after edge k+16; SLL amount 0 -> result=a after edge k+1.
REQ-036 Reset during NIB idx=2 -> ready=1 and result=0 immediately, with no done pulse; start held high during a busy SHIFT -> ignored, only one done pulse.
REQ-037 op=3'b111 -> err=1, result=0, zero=1, done after edge k+1.
